hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Generates per-register enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves three hazard sources:
  - load-use (bubble),
  - taken branch/jump in EX (squash),
  - data-memory wait in MEM (freeze plus writeback bubble, with timeout).
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- REG_W, 5, register index width.
- MEM_TIMEOUT, 16, max consecutive memory-wait cycles before abort (≥2).
- CNT_W, 32, width of the stall_cycles counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- id_rs1  in  REG_W  source reg 1 of the instruction in ID
- id_rs2  in  REG_W  source reg 2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  REG_W  destination of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_redirect  in  1  EX branch taken or jump
- mem_req  in  1  MEM stage is performing a data access
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to bubble
- idex_en  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX clear to bubble
- exmem_en  out  1  EX/MEM load enable
- memwb_flush  out  1  MEM/WB loads bubble instead of MEM data
- mem_abort  out  1  one-cycle pulse, timed-out access abandoned
- mem_err  out  1  sticky error flag, cleared only by reset
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Clock, reset and register model:
  - One clock domain: clk.
  - rst is asynchronous, active-high.
  - Registered state: fsm, wait_cnt, mem_err, stall_cycles.
- Reset values:
  - fsm=RUN, wait_cnt=0, mem_err=0, stall_cycles=0.
  - While rst is high, combinational outputs are forced: all *_en=0, all *_flush=1, mem_abort=0.
- Hazard signals:
  - load_use = ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - mem_stall = mem_req & ~mem_ready & ~timeout, where timeout = (fsm==WAIT & wait_cnt==MEM_TIMEOUT-1).
- Priority, highest first:
  1. mem_stall:
     - pc_en=ifid_en=idex_en=exmem_en=0.
     - memwb_flush=1.
     - No other flushes; ex_redirect and load_use are ignored and re-evaluated once the freeze lifts.
  2. timeout:
     - mem_abort=1, mem_err←1.
     - memwb_flush=1 (no writeback); upstream stages advance normally, and rules 3/4 still apply.
  3. ex_redirect:
     - ifid_flush=1, idex_flush=1, pc_en=1.
     - Overrides load_use, because the dependent instruction is squashed.
  4. load_use:
     - pc_en=0, ifid_en=0, idex_flush=1; EX/MEM advances.
  5. Otherwise: all enables 1, all flushes 0.
- Enables default to 1 and flushes to 0 unless overridden above; exmem_en=0 only under mem_stall.
- FSM (combinational outputs; only state and counters are registered):
  - RUN:
    - If mem_stall: →WAIT, wait_cnt←1.
    - Otherwise stay in RUN.
  - WAIT:
    - If mem_ready or ~mem_req: →RUN, wait_cnt←0.
    - Else if timeout: →RUN, wait_cnt←0.
    - Else wait_cnt←wait_cnt+1.
  - The completing cycle (mem_ready=1) is not a stall cycle: the pipeline advances that cycle.
- Counters:
  - stall_cycles increments each cycle pc_en=0 (rst low) and saturates at all-ones.
  - wait_cnt never exceeds MEM_TIMEOUT-1.
- Boundaries:
  - mem_ready in the same cycle as mem_req: zero stall.
  - mem_ready at wait_cnt==MEM_TIMEOUT-1: completes normally, no abort (ready wins over timeout).
  - ex_rd==0 never triggers load_use.
  - Asynchronous reset mid-WAIT: immediate return to RUN, counters cleared.

Decomposition:
- Shared core package holds:
  - typedef hz_ctrl_t, a struct of all enable/flush bits;
  - enum fsm_e {RUN, WAIT};
  - constant REG_ZERO.
- One natural sub-module: hazard_detect, purely combinational, computing load_use from the ID/EX fields.
- The FSM, priority mux and counters stay in hazard_ctrl.

Test Plan:
- Load x5 in EX, ID reads rs1=x5 with id_use_rs1=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_cycles=1.
- Load x0 in EX with ID reading x0 → no stall; all en=1, flushes=0.
- ex_redirect=1 together with load_use=1 → ifid_flush=idex_flush=1, pc_en=1, stall_cycles unchanged.
- mem_req=1, mem_ready low for 3 cycles then high:
  - 3 cycles of all en=0 and memwb_flush=1;
  - the 4th cycle advances normally;
  - stall_cycles=3, mem_err=0.
- MEM_TIMEOUT=4, mem_ready never asserted:
  - 3 stall cycles, then mem_abort pulses for 1 cycle with memwb_flush=1 and pipeline enables=1;
  - mem_err stays 1 afterwards.
- Assert rst mid-WAIT (wait_cnt=2):
  - immediately fsm=RUN, wait_cnt=0, stall_cycles=0, mem_err=0;
  - while rst is high, outputs are en=0 and flush=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
//   Shared definitions for the 5-stage core's pipeline sequencer.
//   - hz_ctrl_t : bundle of every pipeline-register enable/flush bit
//   - fsm_e     : memory-wait sequencer states
//   - REG_ZERO  : index of the hard-wired zero register
//   - ctrl_run / ctrl_reset : canonical control bundles
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  // Register x0 is hard-wired to zero, so a write to it can never create a
  // true data dependency.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } fsm_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_flush;
  } hz_ctrl_t;

  // Free-running pipeline: everything advances, nothing is squashed.
  function automatic hz_ctrl_t ctrl_run();
    hz_ctrl_t c;
    c.pc_en       = 1'b1;
    c.ifid_en     = 1'b1;
    c.ifid_flush  = 1'b0;
    c.idex_en     = 1'b1;
    c.idex_flush  = 1'b0;
    c.exmem_en    = 1'b1;
    c.memwb_flush = 1'b1 & 1'b0;
    return c;
  endfunction

  // Held in reset: nothing loads, every register is cleared to a bubble.
  function automatic hz_ctrl_t ctrl_reset();
    hz_ctrl_t c;
    c.pc_en       = 1'b0;
    c.ifid_en     = 1'b0;
    c.ifid_flush  = 1'b1;
    c.idex_en     = 1'b0;
    c.idex_flush  = 1'b1;
    c.exmem_en    = 1'b0;
    c.memwb_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
//   Purely combinational load-use detector. Flags when the instruction in ID
//   reads a register that the load currently in EX has not yet produced.
//
//   Ports:
//     id_rs1, id_rs2         in  source registers of the ID instruction
//     id_use_rs1, id_use_rs2 in  ID instruction actually reads rs1 / rs2
//     ex_rd                  in  destination of the EX instruction
//     ex_mem_read            in  EX instruction is a load
//     load_use               out bubble required between ID and EX
// -----------------------------------------------------------------------------
module hazard_detect
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  logic rd_live;
  logic hit_rs1;
  logic hit_rs2;

  // A load into x0 is architecturally discarded, so it never blocks ID.
  assign rd_live = ex_mem_read && (ex_rd != REG_W'(REG_ZERO));
  assign hit_rs1 = id_use_rs1 && (id_rs1 == ex_rd);
  assign hit_rs2 = id_use_rs2 && (id_rs2 == ex_rd);

  assign load_use = rd_live && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Central pipeline sequencer for the 5-stage core. Produces the per-register
//   enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB and resolves
//   load-use bubbles, taken-redirect squashes and data-memory waits (with a
//   timeout that abandons a stuck access). Counts stalled cycles.
//
//   Ports:
//     clk, rst                  clock, asynchronous active-high reset
//     id_rs1/id_rs2             ID source registers
//     id_use_rs1/id_use_rs2     ID instruction reads rs1 / rs2
//     ex_rd, ex_mem_read        EX destination, EX instruction is a load
//     ex_redirect               EX branch taken or jump
//     mem_req, mem_ready        MEM data access handshake
//     pc_en .. memwb_flush      pipeline register controls (combinational)
//     mem_abort                 one-cycle pulse, timed-out access abandoned
//     mem_err                   sticky timeout flag, cleared only by reset
//     stall_cycles              saturating count of cycles with pc_en=0
//     dbg_fsm, dbg_wait_cnt     sequencer state and wait counter, for debug
//
//   Memory handshake: mem_req is held high by the MEM stage for as long as it
//   has an access outstanding; the access completes in the first cycle where
//   mem_req and mem_ready are both high. Every cycle with mem_req high and
//   mem_ready low is a wait cycle, except the timeout cycle, in which the
//   access is dropped instead.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REG_W-1:0]               id_rs1,
  input  logic [REG_W-1:0]               id_rs2,
  input  logic                           id_use_rs1,
  input  logic                           id_use_rs2,
  input  logic [REG_W-1:0]               ex_rd,
  input  logic                           ex_mem_read,
  input  logic                           ex_redirect,
  input  logic                           mem_req,
  input  logic                           mem_ready,
  output logic                           pc_en,
  output logic                           ifid_en,
  output logic                           ifid_flush,
  output logic                           idex_en,
  output logic                           idex_flush,
  output logic                           exmem_en,
  output logic                           memwb_flush,
  output logic                           mem_abort,
  output logic                           mem_err,
  output logic [CNT_W-1:0]               stall_cycles,
  output logic                           dbg_fsm,
  output logic [$clog2(MEM_TIMEOUT)-1:0] dbg_wait_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fsm_e             fsm;
  logic [WC_W-1:0]  wait_cnt;

  // ---------------------------------------------------------------------------
  // Hazard sources
  // ---------------------------------------------------------------------------
  logic load_use;
  logic timeout;
  logic timeout_hit;
  logic mem_stall;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // The last permitted wait cycle. If the memory answers in this cycle the
  // access still completes normally; only a still-pending access is dropped.
  assign timeout     = (fsm == WAIT) && (wait_cnt == WC_LAST);
  assign timeout_hit = timeout && mem_req && !mem_ready;
  assign mem_stall   = mem_req && !mem_ready && !timeout;

  // ---------------------------------------------------------------------------
  // Priority mux: mem_stall > timeout > ex_redirect > load_use > run
  // ---------------------------------------------------------------------------
  hz_ctrl_t ctrl;
  logic     abort_c;

  always_comb begin
    ctrl    = ctrl_run();
    abort_c = 1'b0;

    if (mem_stall) begin
      // Full freeze; redirect and load-use are re-evaluated once it lifts,
      // since the instructions carrying them have not moved.
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_en     = 1'b0;
      ctrl.idex_en     = 1'b0;
      ctrl.exmem_en    = 1'b0;
      ctrl.memwb_flush = 1'b1;
    end else begin
      if (timeout_hit) begin
        // Abandoned access must not write back; upstream keeps flowing.
        abort_c          = 1'b1;
        ctrl.memwb_flush = 1'b1;
      end

      if (ex_redirect) begin
        // The load-use consumer sits in ID and is squashed here anyway.
        ctrl.pc_en      = 1'b1;
        ctrl.ifid_flush = 1'b1;
        ctrl.idex_flush = 1'b1;
      end else if (load_use) begin
        ctrl.pc_en      = 1'b0;
        ctrl.ifid_en    = 1'b0;
        ctrl.idex_flush = 1'b1;
      end
    end

    if (rst) begin
      ctrl    = ctrl_reset();
      abort_c = 1'b0;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_en     = ctrl.idex_en;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_flush = ctrl.memwb_flush;
  assign mem_abort   = abort_c;

  // ---------------------------------------------------------------------------
  // Sequencer, error flag and stall counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm          <= RUN;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (timeout_hit) begin
        mem_err <= 1'b1;
      end

      if (!ctrl.pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end

      case (fsm)
        RUN: begin
          if (mem_stall) begin
            fsm      <= WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        WAIT: begin
          // Completion, withdrawal and timeout all return to RUN; otherwise
          // keep counting. timeout caps wait_cnt at MEM_TIMEOUT-1.
          if (mem_ready || !mem_req || timeout) begin
            fsm      <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        default: begin
          fsm      <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign dbg_fsm      = fsm;
  assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed self-checking bench for hazard_ctrl, built with MEM_TIMEOUT=4 and
//   a 4-bit stall counter so timeout and saturation are reached quickly.
//   Control vector layout used in checks:
//     {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int REG_W       = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  // Expected control vectors
  localparam logic [6:0] C_RST    = 7'b0010101;
  localparam logic [6:0] C_RUN    = 7'b1101010;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_REDIR  = 7'b1111110;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_ABORT  = 7'b1101011;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic             mem_req, mem_ready;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, memwb_flush, mem_abort, mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic             dbg_fsm;
  logic [1:0]       dbg_wait_cnt;

  hazard_ctrl #(
    .REG_W       (REG_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_flush   (idex_flush),
    .exmem_en     (exmem_en),
    .memwb_flush  (memwb_flush),
    .mem_abort    (mem_abort),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .dbg_fsm      (dbg_fsm),
    .dbg_wait_cnt (dbg_wait_cnt)
  );

  logic [6:0] ctrl_v;
  assign ctrl_v = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush};

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; ex_redirect = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic drive_load_use(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                                input logic [REG_W-1:0] rs2, input logic u1, input logic u2);
    ex_mem_read = 1; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2;
  endtask

  // Advance to 1 time unit after the next rising edge, then settle inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard checks
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [6:0] c, input logic ab,
                           input logic err, input logic [CNT_W-1:0] sc);
    chk({tag, ".ctrl"}, 32'(ctrl_v), 32'(c));
    chk({tag, ".abort"}, 32'(mem_abort), 32'(ab));
    chk({tag, ".err"}, 32'(mem_err), 32'(err));
    chk({tag, ".stall"}, 32'(stall_cycles), 32'(sc));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    #2;
    chk_state("reset", C_RST, 0, 0, 0);
    chk("reset.fsm", 32'(dbg_fsm), 0);
    chk("reset.wcnt", 32'(dbg_wait_cnt), 0);

    step();
    rst = 0;
    #1;
    chk_state("idle", C_RUN, 0, 0, 0);

    // Load x5, ID reads rs1=x5: one bubble
    drive_load_use(5, 5, 9, 1, 0);
    #1 chk_state("lu_rs1", C_LU, 0, 0, 0);
    step(); idle_inputs();
    #1 chk_state("lu_rs1_after", C_RUN, 0, 0, 1);

    // rs2 match
    drive_load_use(7, 3, 7, 0, 1);
    #1 chk_state("lu_rs2", C_LU, 0, 0, 1);
    step();
    // same registers but rs2 not used: no hazard
    drive_load_use(7, 3, 7, 1, 0);
    #1 chk_state("lu_rs2_unused", C_RUN, 0, 0, 2);
    // load not a load: no hazard
    ex_mem_read = 0; id_rs1 = 7;
    #1 chk_state("lu_not_load", C_RUN, 0, 0, 2);
    step();

    // Load x0, ID reads x0: never a hazard
    drive_load_use(0, 0, 0, 1, 1);
    #1 chk_state("lu_x0", C_RUN, 0, 0, 2);
    step();

    // Redirect overrides load-use
    drive_load_use(4, 4, 0, 1, 0);
    ex_redirect = 1;
    #1 chk_state("redir_lu", C_REDIR, 0, 0, 2);
    step(); idle_inputs();
    #1 chk_state("redir_after", C_RUN, 0, 0, 2);

    // Memory wait: 3 stall cycles, ready arrives at wait_cnt==3 (ready beats timeout)
    mem_req = 1; mem_ready = 0;
    #1 chk_state("mw_c1", C_FREEZE, 0, 0, 2);
    step();
    chk("mw_c2.fsm", 32'(dbg_fsm), 1);
    chk("mw_c2.wcnt", 32'(dbg_wait_cnt), 1);
    ex_redirect = 1; drive_load_use(6, 6, 0, 1, 0);
    #1 chk_state("mw_c2_ignore", C_FREEZE, 0, 0, 3);
    step(); idle_inputs(); mem_req = 1;
    #1 chk_state("mw_c3", C_FREEZE, 0, 0, 4);
    step();
    chk("mw_c4.wcnt", 32'(dbg_wait_cnt), 3);
    mem_ready = 1;
    #1 chk_state("mw_ready", C_RUN, 0, 0, 5);
    step(); idle_inputs();
    chk("mw_done.fsm", 32'(dbg_fsm), 0);
    chk("mw_done.wcnt", 32'(dbg_wait_cnt), 0);
    chk_state("mw_done", C_RUN, 0, 0, 5);

    // Zero-stall access
    mem_req = 1; mem_ready = 1;
    #1 chk_state("mem_zero", C_RUN, 0, 0, 5);
    step(); idle_inputs();
    chk("mem_zero.fsm", 32'(dbg_fsm), 0);

    // Timeout: ready never comes
    mem_req = 1; mem_ready = 0;
    step(); step(); step();
    #1 chk_state("to_hit", C_ABORT, 1, 0, 8);
    chk("to_hit.wcnt", 32'(dbg_wait_cnt), 3);
    step(); mem_req = 0;
    #1 chk_state("to_after", C_RUN, 0, 1, 8);
    chk("to_after.fsm", 32'(dbg_fsm), 0);
    chk("to_after.wcnt", 32'(dbg_wait_cnt), 0);
    step();
    chk_state("to_sticky", C_RUN, 0, 1, 8);

    // Asynchronous reset in the middle of WAIT
    mem_req = 1; mem_ready = 0;
    step(); step();
    chk("rw_pre.fsm", 32'(dbg_fsm), 1);
    chk("rw_pre.wcnt", 32'(dbg_wait_cnt), 2);
    chk("rw_pre.stall", 32'(stall_cycles), 10);
    #2 rst = 1;
    #1 chk_state("rw_rst", C_RST, 0, 0, 0);
    chk("rw_rst.fsm", 32'(dbg_fsm), 0);
    chk("rw_rst.wcnt", 32'(dbg_wait_cnt), 0);
    step(); idle_inputs(); rst = 0;
    #1 chk_state("rw_release", C_RUN, 0, 0, 0);

    // Stall counter saturates at all-ones
    drive_load_use(8, 8, 0, 1, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat.stall", 32'(stall_cycles), 15);
    idle_inputs();
    step();
    chk("sat.hold", 32'(stall_cycles), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
